// File: rtl/usb_spi_responder.sv
// rtl/usb_spi_responder.sv - SPI mode-0 slave exposing a 32x8 register file with a W1C interrupt register
// Optional feature: define SPI_RESPONDER_AUTOINC_EN to advance the address after every data byte.
`timescale 1ns/1ps
module usb_spi_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int IRQ_REG     = 25,
  parameter int IEN_REG     = 26
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic       spi0_SCLK,
  input  logic       spi0_MOSI,
  input  logic       spi0_SS_n,
  output logic       spi0_MISO,
  input  logic [7:0] set_irq,
  output logic       usb_irq_export,
  output logic       wr_strobe,
  output logic [4:0] wr_addr,
  output logic [7:0] wr_data
);
  localparam logic [4:0] IRQ_ADDR = 5'(IRQ_REG);
  localparam logic [4:0] IEN_ADDR = 5'(IEN_REG);

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;
  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, ss_sync;
  logic       sclk_d, ss_d;
  logic       sclk_s, mosi_s, ss_s;
  logic       sclk_rise, sclk_fall, ss_fall, ss_rise;
  logic [2:0] bit_cnt;
  logic [7:0] shift_in, shift_out, rx_byte;
  logic [4:0] addr, addr_next;
  logic       write_q;
  logic [7:0] regs [32];
  logic [7:0] irq_next;

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];
  assign ss_s   = ss_sync[SYNC_STAGES-1];

  // SCLK edges only count while the synchronized select is asserted
  assign sclk_rise = sclk_s & ~sclk_d & ~ss_s;
  assign sclk_fall = ~sclk_s & sclk_d & ~ss_s;
  assign ss_fall   = ~ss_s & ss_d;
  assign ss_rise   = ss_s & ~ss_d;
  assign rx_byte   = {shift_in[6:0], mosi_s};

`ifdef SPI_RESPONDER_AUTOINC_EN
  assign addr_next = addr + 5'd1;
`else
  assign addr_next = addr;
`endif

  assign spi0_MISO = (state_q != IDLE) && !ss_s && shift_out[7];

  // Select resets to "asserted" so a transfer already running at reset release is never picked up
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      ss_sync   <= '0;
      sclk_d    <= 1'b0;
      ss_d      <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi0_SCLK};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi0_MOSI};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], spi0_SS_n};
      sclk_d    <= sclk_s;
      ss_d      <= ss_s;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) state_q <= IDLE;
    else                state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ss_fall) state_d = CMD;
      CMD: begin
        if (ss_rise)                              state_d = IDLE;
        else if (sclk_rise && bit_cnt == 3'd7)    state_d = DATA;
      end
      DATA:    if (ss_rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The next MISO byte is loaded on the fall that closes a byte so its MSB is not shifted away
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      bit_cnt   <= 3'd0;
      shift_in  <= 8'h00;
      shift_out <= 8'h00;
      addr      <= 5'd0;
      write_q   <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= 5'd0;
      wr_data   <= 8'h00;
    end else begin
      wr_strobe <= 1'b0;
      if (state_q == IDLE) begin
        bit_cnt  <= 3'd0;
        shift_in <= 8'h00;
        if (ss_fall) shift_out <= regs[IRQ_ADDR];
      end else if (ss_rise) begin
        bit_cnt   <= 3'd0;
        shift_in  <= 8'h00;
        shift_out <= 8'h00;
      end else begin
        if (sclk_rise) begin
          shift_in <= rx_byte;
          bit_cnt  <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            if (state_q == CMD) begin
              addr    <= rx_byte[7:3];
              write_q <= rx_byte[1];
            end else begin
              if (write_q) begin
                wr_strobe <= 1'b1;
                wr_addr   <= addr;
                wr_data   <= rx_byte;
              end
              addr <= addr_next;
            end
          end
        end
        if (sclk_fall) begin
          if (bit_cnt == 3'd0) shift_out <= write_q ? 8'h00 : regs[addr];
          else                 shift_out <= {shift_out[6:0], 1'b0};
        end
      end
    end
  end

  // Local set bits are applied after the write-1-to-clear so a same-cycle set survives
  always_comb begin
    irq_next = regs[IRQ_ADDR];
    if (wr_strobe && wr_addr == IRQ_ADDR) irq_next = regs[IRQ_ADDR] & ~wr_data;
    irq_next = irq_next | set_irq;
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= 8'h00;
      usb_irq_export <= 1'b0;
    end else begin
      if (wr_strobe && wr_addr != IRQ_ADDR) regs[wr_addr] <= wr_data;
      regs[IRQ_ADDR] <= irq_next;
      usb_irq_export <= |(regs[IRQ_ADDR] & regs[IEN_ADDR]);
    end
  end

endmodule

// File: tb/tb_usb_spi_responder.sv
// tb/tb_usb_spi_responder.sv - scoreboard bench driving usb_spi_responder as an SPI master
`timescale 1ns/1ps
module tb_usb_spi_responder;
  localparam int HALF = 80;
`ifdef SPI_RESPONDER_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       sclk = 1'b0;
  logic       mosi = 1'b0;
  logic       ss_n = 1'b1;
  logic [7:0] set_irq = 8'h00;
  logic       miso, irq, wr_strobe;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;

  int checks = 0;
  int errors = 0;
  logic [12:0] exp_wr[$];
  logic [7:0]  exp_rx[$];
  logic [7:0]  act_rx[$];
  logic [7:0]  mdl [32];
  logic [7:0]  rx;

  always #5 clk = ~clk;

  usb_spi_responder dut (
    .clk_clk(clk),
    .reset_reset_n(rstn),
    .spi0_SCLK(sclk),
    .spi0_MOSI(mosi),
    .spi0_SS_n(ss_n),
    .spi0_MISO(miso),
    .set_irq(set_irq),
    .usb_irq_export(irq),
    .wr_strobe(wr_strobe),
    .wr_addr(wr_addr),
    .wr_data(wr_data)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: pops an expectation whenever the DUT commits a write or a MISO byte is captured
  always @(negedge clk) begin
    logic [12:0] e;
    logic [7:0]  a;
    if (wr_strobe === 1'b1) begin
      if (exp_wr.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wr_unexpected actual addr=%0d data=%h required=no strobe", wr_addr, wr_data);
      end else begin
        e = exp_wr.pop_front();
        check("wr_commit", {19'd0, wr_addr, wr_data}, {19'd0, e});
      end
    end
    while (act_rx.size() > 0) begin
      a = act_rx.pop_front();
      if (exp_rx.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL miso_unexpected actual=%h required=none", a);
      end else begin
        check("miso_byte", {24'd0, a}, {24'd0, exp_rx.pop_front()});
      end
    end
  end

  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] r);
    r = 8'h00;
    for (int i = 7; i >= 8 - n; i--) begin
      mosi = tx[i];
      #HALF;
      sclk = 1'b1;
      r[i] = miso;
      #HALF;
      sclk = 1'b0;
    end
  endtask

  task automatic ss_begin();
    @(negedge clk);
    ss_n = 1'b0;
    #HALF;
  endtask

  task automatic ss_end();
    #HALF;
    ss_n = 1'b1;
    #(4 * HALF);
  endtask

  task automatic do_xfer(input logic [7:0] cmd, input int n, input logic [7:0] d0, input logic [7:0] d1);
    logic [4:0] a;
    logic [7:0] d, r;
    a = cmd[7:3];
    ss_begin();
    exp_rx.push_back(mdl[25]);
    spi_bits(cmd, 8, r);
    act_rx.push_back(r);
    for (int k = 0; k < n; k++) begin
      d = (k == 0) ? d0 : d1;
      if (cmd[1]) begin
        exp_rx.push_back(8'h00);
        exp_wr.push_back({a, d});
        if (a == 5'd25) mdl[a] = mdl[a] & ~d;
        else            mdl[a] = d;
      end else begin
        exp_rx.push_back(mdl[a]);
      end
      spi_bits(d, 8, r);
      act_rx.push_back(r);
      if (AUTOINC) a = a + 5'd1;
    end
    ss_end();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_miso"}, miso, 0);
    check({tag, "_irq"}, irq, 0);
    check({tag, "_wr_strobe"}, wr_strobe, 0);
    check({tag, "_wr_addr"}, wr_addr, 0);
    check({tag, "_wr_data"}, wr_data, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) mdl[i] = 8'h00;
    rstn = 1'b0;
    repeat (4) @(negedge clk);
    check_outputs_zero("reset");
    rstn = 1'b1;
    repeat (4) @(negedge clk);

    // write reg1 = 0x5A, read back; then junk bits in cmd[2]/cmd[0]
    do_xfer(8'h0A, 1, 8'h5A, 8'h00);
    do_xfer(8'h08, 1, 8'h00, 8'h00);
    do_xfer(8'h17, 1, 8'h3C, 8'h00);
    do_xfer(8'h15, 1, 8'h00, 8'h00);

    // interrupt set, enable, status, clear
    @(negedge clk);
    set_irq = 8'h04;
    @(negedge clk);
    set_irq = 8'h00;
    mdl[25] = mdl[25] | 8'h04;
    repeat (3) @(negedge clk);
    check("irq_masked", irq, 0);
    do_xfer(8'hD2, 1, 8'h04, 8'h00);
    check("irq_enabled", irq, 1);
    do_xfer(8'h08, 1, 8'h00, 8'h00);
    do_xfer(8'hCA, 1, 8'h04, 8'h00);
    check("irq_cleared", irq, 0);

    // set_irq in the commit cycle of a W1C write of the same bit
    fork
      begin
        for (int c = 0; c < 20000; c++) begin
          @(negedge clk);
          if (wr_strobe === 1'b1) begin
            set_irq = 8'h04;
            @(negedge clk);
            set_irq = 8'h00;
            break;
          end
        end
      end
    join_none
    do_xfer(8'hCA, 1, 8'h04, 8'h00);
    mdl[25] = mdl[25] | 8'h04;
    check("irq_collision", irq, 1);
    do_xfer(8'hC8, 1, 8'h00, 8'h00);

    // burst across reg31 -> reg0
    do_xfer(8'hFA, 2, 8'h11, 8'h22);
    do_xfer(8'hF8, 2, 8'h00, 8'h00);
    do_xfer(8'h00, 1, 8'h00, 8'h00);

    // abort after 5 data bits of a write to reg3
    ss_begin();
    exp_rx.push_back(mdl[25]);
    spi_bits(8'h1A, 8, rx);
    act_rx.push_back(rx);
    spi_bits(8'hFF, 5, rx);
    ss_end();
    do_xfer(8'h18, 1, 8'h00, 8'h00);

    // reset in the middle of a data byte, SS held low through release
    ss_begin();
    exp_rx.push_back(mdl[25]);
    spi_bits(8'h22, 8, rx);
    act_rx.push_back(rx);
    spi_bits(8'hA5, 3, rx);
    @(negedge clk);
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    check_outputs_zero("midreset");
    rstn = 1'b1;
    for (int i = 0; i < 32; i++) mdl[i] = 8'h00;
    spi_bits(8'hFF, 8, rx);
    check("miso_stale_xfer", miso, 0);
    ss_end();
    do_xfer(8'h0A, 1, 8'h77, 8'h00);
    do_xfer(8'h08, 1, 8'h00, 8'h00);
    do_xfer(8'h20, 1, 8'h00, 8'h00);

    repeat (10) @(negedge clk);
    check("exp_wr_drained", exp_wr.size(), 0);
    check("exp_rx_drained", exp_rx.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
